// File: rtl/stopwatch_display_reader.sv
// Receive-side monitor for the stopwatch's four seven-segment outputs: debounces the
// segment buses, decodes them back to BCD/seconds and classifies each accepted change.
module stopwatch_display_reader #(
  parameter int STABLE_CYCLES  = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic        in_clk,
  input  logic        reset,
  input  logic [6:0]  seg_S0,
  input  logic [6:0]  seg_S1,
  input  logic [6:0]  seg_M0,
  input  logic [6:0]  seg_M1,
  input  logic        clear_counts,
  output logic [3:0]  dig_S0,
  output logic [3:0]  dig_S1,
  output logic [3:0]  dig_M0,
  output logic [3:0]  dig_M1,
  output logic [12:0] total_sec,
  output logic        locked,
  output logic        step_up,
  output logic        step_down,
  output logic        step_jump,
  output logic        step_clear,
  output logic        step_err,
  output logic        invalid_seg,
  output logic [15:0] up_count,
  output logic [7:0]  err_count
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_SETTLE,
    ST_LOCKED
  } state_t;

  localparam logic [7:0]  STABLE_LIM = 8'(STABLE_CYCLES);
  localparam logic [7:0]  STABLE_M1  = 8'(STABLE_CYCLES - 1);
  localparam logic [6:0]  SEG_MASK   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [12:0] MOD_SEC    = 13'd6000;

  // {valid, digit}; anything outside the ten legal glyphs (blank included) is invalid
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    case (p)
      7'h3F:   return {1'b1, 4'd0};
      7'h06:   return {1'b1, 4'd1};
      7'h5B:   return {1'b1, 4'd2};
      7'h4F:   return {1'b1, 4'd3};
      7'h66:   return {1'b1, 4'd4};
      7'h6D:   return {1'b1, 4'd5};
      7'h7D:   return {1'b1, 4'd6};
      7'h07:   return {1'b1, 4'd7};
      7'h7F:   return {1'b1, 4'd8};
      7'h6F:   return {1'b1, 4'd9};
      default: return 5'd0;
    endcase
  endfunction

  // digits packed as {M1, M0, S1, S0}
  function automatic logic [12:0] to_seconds(input logic [15:0] d);
    return 13'(d[15:12]) * 13'd600 + 13'(d[11:8]) * 13'd60
         + 13'(d[7:4]) * 13'd10 + 13'(d[3:0]);
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic [1:0] n);
    logic [8:0] s;
    s = {1'b0, v} + 9'(n);
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  logic [4:0]  dec_s0, dec_s1, dec_m0, dec_m1;
  logic [15:0] in_dig;
  logic        in_vld;

  logic [15:0] samp_dig_q;
  logic        samp_vld_q;
  logic        invalid_q, invalid_d;
  logic [7:0]  cnt_q, cnt_d;
  state_t      state_q, state_d;
  logic [15:0] acc_dig_q, acc_dig_d;
  logic [12:0] total_q, total_d;
  logic [4:0]  pulse_q, pulse_d;
  logic [15:0] up_q, up_d;
  logic [7:0]  err_q, err_d;

  logic        same, hit, accept, at_acc;
  logic [12:0] new_total, delta;
  logic [1:0]  err_inc;

  assign dec_s0 = seg_decode(seg_S0 ^ SEG_MASK);
  assign dec_s1 = seg_decode(seg_S1 ^ SEG_MASK);
  assign dec_m0 = seg_decode(seg_M0 ^ SEG_MASK);
  assign dec_m1 = seg_decode(seg_M1 ^ SEG_MASK);
  assign in_dig = {dec_m1[3:0], dec_m0[3:0], dec_s1[3:0], dec_s0[3:0]};
  assign in_vld = dec_s0[4] & dec_s1[4] & dec_m0[4] & dec_m1[4] & (dec_s1[3:0] <= 4'd5);

  // The edge that registers a repeat of the held sample is one "stable" edge, so a
  // pattern first registered at edge N is accepted at edge N+STABLE_CYCLES.
  assign same      = in_vld && samp_vld_q && (in_dig == samp_dig_q);
  assign hit       = same && (cnt_q == STABLE_M1);
  assign at_acc    = in_vld && (in_dig == acc_dig_q);
  assign accept    = hit && ((state_q == ST_EMPTY) || (in_dig != acc_dig_q));
  assign new_total = to_seconds(in_dig);
  // modulo-6000 difference; the 13-bit wrap in the second form cancels out
  assign delta     = (new_total >= total_q) ? (new_total - total_q)
                                            : (new_total + MOD_SEC - total_q);

  always_comb begin
    state_d   = state_q;
    acc_dig_d = acc_dig_q;
    total_d   = total_q;
    pulse_d   = 5'b00000;
    invalid_d = !in_vld;

    if (!same) begin
      cnt_d = 8'd0;
    end else if (cnt_q >= STABLE_LIM) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end

    if (accept) begin
      acc_dig_d = in_dig;
      total_d   = new_total;
    end

    // classification pulses {up, down, jump, clear, err}, first match wins
    if (accept && (state_q != ST_EMPTY)) begin
      if ((new_total == 13'd0) && (delta != 13'd1)) begin
        pulse_d = 5'b00010;
      end else if (delta == 13'd1) begin
        pulse_d = 5'b10000;
      end else if (delta == 13'd5999) begin
        pulse_d = 5'b01000;
      end else if ((delta == 13'd120) || (delta == 13'd5880)) begin
        pulse_d = 5'b00100;
      end else begin
        pulse_d = 5'b00001;
      end
    end

    case (state_q)
      ST_EMPTY: begin
        if (accept) state_d = ST_LOCKED;
      end
      ST_LOCKED: begin
        if (!accept && !at_acc) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (accept || at_acc) state_d = ST_LOCKED;
      end
      default: state_d = ST_EMPTY;
    endcase

    err_inc = 2'(pulse_d[0]) + 2'(invalid_d && !invalid_q);
    if (clear_counts) begin
      up_d  = 16'd0;
      err_d = 8'd0;
    end else begin
      up_d  = pulse_d[4] ? sat_inc16(up_q) : up_q;
      err_d = sat_add8(err_q, err_inc);
    end
  end

  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      samp_dig_q <= '0;
      samp_vld_q <= 1'b0;
      invalid_q  <= 1'b0;
      cnt_q      <= '0;
      state_q    <= ST_EMPTY;
      acc_dig_q  <= '0;
      total_q    <= '0;
      pulse_q    <= '0;
      up_q       <= '0;
      err_q      <= '0;
    end else begin
      samp_dig_q <= in_dig;
      samp_vld_q <= in_vld;
      invalid_q  <= invalid_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      acc_dig_q  <= acc_dig_d;
      total_q    <= total_d;
      pulse_q    <= pulse_d;
      up_q       <= up_d;
      err_q      <= err_d;
    end
  end

  assign dig_S0      = acc_dig_q[3:0];
  assign dig_S1      = acc_dig_q[7:4];
  assign dig_M0      = acc_dig_q[11:8];
  assign dig_M1      = acc_dig_q[15:12];
  assign total_sec   = total_q;
  assign locked      = (state_q != ST_EMPTY);
  assign step_up     = pulse_q[4];
  assign step_down   = pulse_q[3];
  assign step_jump   = pulse_q[2];
  assign step_clear  = pulse_q[1];
  assign step_err    = pulse_q[0];
  assign invalid_seg = invalid_q;
  assign up_count    = up_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_stopwatch_display_reader.sv
// Scoreboard bench for stopwatch_display_reader: display segments of random length are
// driven, a segment-level model predicts acceptances, a monitor checks emitted events.
module tb_stopwatch_display_reader;

  localparam int S  = 4;
  localparam bit AL = 1'b0;
  localparam logic [6:0] MASK = AL ? 7'h7F : 7'h00;

  logic        in_clk = 1'b0;
  logic        reset;
  logic [6:0]  seg_S0, seg_S1, seg_M0, seg_M1;
  logic        clear_counts;
  logic [3:0]  dig_S0, dig_S1, dig_M0, dig_M1;
  logic [12:0] total_sec;
  logic        locked, step_up, step_down, step_jump, step_clear, step_err, invalid_seg;
  logic [15:0] up_count;
  logic [7:0]  err_count;

  stopwatch_display_reader #(.STABLE_CYCLES(S), .SEG_ACTIVE_LOW(AL)) dut (
    .in_clk(in_clk), .reset(reset),
    .seg_S0(seg_S0), .seg_S1(seg_S1), .seg_M0(seg_M0), .seg_M1(seg_M1),
    .clear_counts(clear_counts),
    .dig_S0(dig_S0), .dig_S1(dig_S1), .dig_M0(dig_M0), .dig_M1(dig_M1),
    .total_sec(total_sec), .locked(locked),
    .step_up(step_up), .step_down(step_down), .step_jump(step_jump),
    .step_clear(step_clear), .step_err(step_err), .invalid_seg(invalid_seg),
    .up_count(up_count), .err_count(err_count)
  );

  always #5 in_clk = ~in_clk;

  typedef struct {int kind; int total; int up; int err;} ev_t;
  ev_t q[$];

  int checks = 0;
  int errors = 0;
  // model state: accepted value, lock flag, counters, last segment value (-1 invalid, -2 none)
  int m_total, m_locked, m_up, m_err, prev_val, m_inv_cycles;
  int mon_inv = 0;
  logic lock_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] pat(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F; 4: return 7'h66;
      5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07; 8: return 7'h7F; default: return 7'h6F;
    endcase
  endfunction

  function automatic bit legal(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (pat(i) == p) return 1'b1;
    return 1'b0;
  endfunction

  // 1 up, 2 down, 3 jump, 4 clear, 5 err
  function automatic int classify(input int oldv, input int newv);
    int d;
    d = ((newv - oldv) % 6000 + 6000) % 6000;
    if (newv == 0 && d != 1) return 4;
    if (d == 1) return 1;
    if (d == 5999) return 2;
    if (d == 120 || d == 5880) return 3;
    return 5;
  endfunction

  task automatic drive_val(input int t);
    seg_M1 = pat(t / 600) ^ MASK;
    seg_M0 = pat((t / 60) % 10) ^ MASK;
    seg_S1 = pat((t % 60) / 10) ^ MASK;
    seg_S0 = pat(t % 10) ^ MASK;
  endtask

  task automatic check_state(input string nm, input bit inv);
    chk({nm, ".total"}, 32'(total_sec), 32'(m_total));
    chk({nm, ".dig"}, {16'd0, dig_M1, dig_M0, dig_S1, dig_S0},
        32'(((m_total / 600) << 12) | (((m_total / 60) % 10) << 8) |
            (((m_total % 60) / 10) << 4) | (m_total % 10)));
    chk({nm, ".locked"}, 32'(locked), 32'(m_locked));
    chk({nm, ".up"}, 32'(up_count), 32'(m_up));
    chk({nm, ".err"}, 32'(err_count), 32'(m_err));
    chk({nm, ".inv"}, 32'(invalid_seg), 32'(inv));
  endtask

  task automatic check_reset(input string nm);
    chk({nm, ".total"}, 32'(total_sec), 0);
    chk({nm, ".dig"}, {16'd0, dig_M1, dig_M0, dig_S1, dig_S0}, 0);
    chk({nm, ".locked"}, 32'(locked), 0);
    chk({nm, ".pulses"}, {27'd0, step_up, step_down, step_jump, step_clear, step_err}, 0);
    chk({nm, ".inv"}, 32'(invalid_seg), 0);
    chk({nm, ".up"}, 32'(up_count), 0);
    chk({nm, ".err"}, 32'(err_count), 0);
  endtask

  // Valid value held for h edges; clear_counts asserted on the last edge when clr.
  task automatic run_seg(input int val, input int h, input bit clr, input bit lat_chk);
    bit acc;
    int old_total, old_locked, kind;
    ev_t e;
    old_total = m_total;
    old_locked = m_locked;
    acc = (h >= S + 1) && (m_locked == 0 || val != m_total);
    if (acc) begin
      kind = (m_locked == 0) ? 0 : classify(m_total, val);
      if (kind == 1) m_up = (m_up == 65535) ? 65535 : m_up + 1;
      if (kind == 5) m_err = (m_err == 255) ? 255 : m_err + 1;
      m_locked = 1;
      m_total = val;
      e.kind = kind; e.total = val; e.up = m_up; e.err = m_err;
      q.push_back(e);
    end
    drive_val(val);
    for (int i = 0; i < h; i++) begin
      clear_counts = clr && (i == h - 1);
      @(posedge in_clk);
      #1;
      if (lat_chk && acc && i == S - 1) begin
        chk("latency.locked", 32'(locked), 32'(old_locked));
        chk("latency.total", 32'(total_sec), 32'(old_total));
      end
    end
    clear_counts = 1'b0;
    if (clr) begin m_up = 0; m_err = 0; end
    prev_val = val;
    check_state("seg", 1'b0);
  endtask

  task automatic inv_seg(input int typ, input int h, input bit clr);
    logic [6:0] r;
    if (prev_val == -1) run_seg(m_total, 1, 1'b0, 1'b0);
    m_err = (m_err == 255) ? 255 : m_err + 1;
    m_inv_cycles += h;
    drive_val(m_total);
    case (typ)
      0: seg_S0 = 7'h00 ^ MASK;
      1: seg_S1 = pat(6) ^ MASK;
      2: begin
        r = 7'($urandom_range(0, 127));
        if (legal(r)) r = 7'h00;
        seg_M0 = r ^ MASK;
      end
      default: seg_M1 = 7'h76 ^ MASK;
    endcase
    for (int i = 0; i < h; i++) begin
      clear_counts = clr && (i == h - 1);
      @(posedge in_clk);
      #1;
    end
    clear_counts = 1'b0;
    if (clr) begin m_up = 0; m_err = 0; end
    prev_val = -1;
    check_state("inv", 1'b1);
  endtask

  // Monitor: any step pulse or a rising locked is one emitted event.
  int ob_kind, n_pulse;
  ev_t ex;
  always @(negedge in_clk) begin
    if (invalid_seg === 1'b1) mon_inv++;
    n_pulse = int'(step_up) + int'(step_down) + int'(step_jump) + int'(step_clear) + int'(step_err);
    if (n_pulse > 0 || (locked && !lock_prev)) begin
      if (n_pulse > 1) ob_kind = 9;
      else if (step_up) ob_kind = 1;
      else if (step_down) ob_kind = 2;
      else if (step_jump) ob_kind = 3;
      else if (step_clear) ob_kind = 4;
      else if (step_err) ob_kind = 5;
      else ob_kind = 0;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: kind %0d total %0d, none expected", ob_kind, total_sec);
      end else begin
        ex = q.pop_front();
        chk("ev.kind", 32'(ob_kind), 32'(ex.kind));
        chk("ev.total", 32'(total_sec), 32'(ex.total));
        chk("ev.up", 32'(up_count), 32'(ex.up));
        chk("ev.err", 32'(err_count), 32'(ex.err));
      end
    end
    lock_prev = locked;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  int r, v, h;
  bit clr;
  initial begin
    reset = 1'b0;
    clear_counts = 1'b0;
    drive_val(0);
    m_total = 0; m_locked = 0; m_up = 0; m_err = 0; prev_val = -2; m_inv_cycles = 0;
    repeat (3) @(posedge in_clk);
    #1;
    check_reset("reset");
    reset = 1'b1;

    // first acceptance, then classified transitions including both wrap directions
    run_seg(0, S + 3, 1'b0, 1'b1);
    run_seg(59, S + 2, 1'b0, 1'b0);
    run_seg(60, S + 1, 1'b0, 1'b1);
    run_seg(5999, S + 2, 1'b0, 1'b0);
    run_seg(0, S + 2, 1'b0, 1'b0);
    run_seg(5999, S + 2, 1'b0, 1'b0);
    run_seg(190, S + 2, 1'b0, 1'b0);
    run_seg(310, S + 2, 1'b0, 1'b0);
    run_seg(190, S + 2, 1'b0, 1'b0);
    run_seg(70, S + 2, 1'b0, 1'b0);
    run_seg(453, S + 2, 1'b0, 1'b0);
    run_seg(0, S + 2, 1'b0, 1'b0);
    run_seg(5, S, 1'b0, 1'b0);
    run_seg(0, S + 2, 1'b0, 1'b0);
    inv_seg(0, 3, 1'b0);
    inv_seg(1, 2, 1'b0);
    run_seg(3, S + 2, 1'b0, 1'b0);

    // reset with a candidate pending
    drive_val(4);
    repeat (2) @(posedge in_clk);
    #1;
    reset = 1'b0;
    #1;
    check_reset("reset_mid");
    @(posedge in_clk);
    #1;
    reset = 1'b1;
    m_total = 0; m_locked = 0; m_up = 0; m_err = 0; prev_val = -2;
    run_seg(100, S + 2, 1'b0, 1'b0);
    run_seg(101, S + 2, 1'b0, 1'b0);

    // drive err_count into saturation, then clear
    for (int i = 0; i < 260; i++) inv_seg(i % 4, 1, 1'b0);
    run_seg(m_total, S + 2, 1'b1, 1'b0);

    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 11);
      h = $urandom_range(S + 1, S + 4);
      clr = 1'b0;
      case (r)
        0, 1, 11: v = (m_total + 1) % 6000;
        2: v = (m_total + 5999) % 6000;
        3: v = (m_total + 120) % 6000;
        4: v = (m_total + 5880) % 6000;
        5: v = 0;
        6: v = 5999;
        7: v = $urandom_range(0, 5999);
        9: begin v = $urandom_range(0, 5999); h = $urandom_range(1, S); end
        10: begin v = (m_total + 1) % 6000; h = $urandom_range(S + 2, S + 4); clr = 1'b1; end
        default: v = -1;
      endcase
      if (r == 8) begin
        inv_seg($urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 7) == 0);
      end else begin
        if (v == prev_val) v = (v + 7) % 6000;
        run_seg(v, h, clr, 1'b0);
      end
    end

    drive_val(m_total);
    repeat (3) @(posedge in_clk);
    #1;
    chk("queue_drained", 32'(q.size()), 0);
    chk("invalid_cycles", 32'(mon_inv), 32'(m_inv_cycles));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
